// File: rtl/servo_ramp_ctrl_if.sv
// Command port of the servo ramp sequencer: host writes per-channel target and slew step.
interface servo_ramp_ctrl_if #(
  parameter int NCH = 4
);
  localparam int CW = $clog2(NCH);

  logic          cmd_valid;
  logic          cmd_ready;
  logic [CW-1:0] cmd_ch;
  logic [7:0]    cmd_target;
  logic [3:0]    cmd_step;

  modport master (output cmd_valid, cmd_ch, cmd_target, cmd_step, input cmd_ready);
  modport slave  (input cmd_valid, cmd_ch, cmd_target, cmd_step, output cmd_ready);
endinterface

// File: rtl/servo_ramp_ctrl.sv
// Multi-channel servo duty sequencer: once per frame, each channel's duty slews toward its
// commanded target by at most its step, one channel per clock.
module servo_ramp_ctrl #(
  parameter int clk_hz    = 25000000,
  parameter int cyc_hz    = 50,
  parameter int NCH       = 4,
  parameter int INIT_DUTY = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  servo_ramp_ctrl_if.slave     cmd,
  output logic [NCH*8-1:0]     duty_flat,
  output logic [NCH-1:0]       moving,
  output logic                 frame_tick,
  output logic                 pdm_en
);
  localparam int FRAME = clk_hz / cyc_hz;
  localparam int CW    = $clog2(NCH);
  localparam int FCW   = $clog2(FRAME);
  localparam logic [FCW-1:0] FRAME_LAST = FCW'(FRAME - 1);
  localparam logic [CW-1:0]  LAST_CH    = CW'(NCH - 1);
  localparam logic [7:0]     INIT       = 8'(INIT_DUTY);

  // The sweep must finish before the next tick can start another one.
  if (FRAME <= NCH + 1) begin : g_frame_chk
    $error("servo_ramp_ctrl: frame length must exceed NCH+1 clocks");
  end

  typedef enum logic {IDLE, UPDATE} state_t;

  state_t        state, state_next;
  logic [CW-1:0] idx, idx_next;
  logic [FCW-1:0] frame_cnt;
  logic          ready;
  logic          fire;

  logic [7:0] duty   [NCH];
  logic [7:0] target [NCH];
  logic [3:0] step   [NCH];

  // Move cur toward tgt by at most stp, clamping at tgt (9-bit math, never wraps).
  function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt,
                                             input logic [3:0] stp);
    logic [8:0] up;
    logic [8:0] gap;
    up  = {1'b0, cur} + {5'd0, stp};
    gap = {1'b0, cur} - {1'b0, tgt};
    if (cur < tgt)
      return (up > {1'b0, tgt}) ? tgt : up[7:0];
    else if (cur > tgt)
      return (gap <= {5'd0, stp}) ? tgt : (cur - {4'd0, stp});
    return cur;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) frame_cnt <= '0;
    else if (frame_tick) frame_cnt <= '0;
    else frame_cnt <= frame_cnt + FCW'(1);
  end

  assign frame_tick = (frame_cnt == FRAME_LAST);

  always_ff @(posedge clk) begin
    if (!rst) pdm_en <= 1'b0;
    else pdm_en <= enable;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    ready      = 1'b0;
    case (state)
      IDLE: begin
        ready = rst;
        if (frame_tick) begin
          state_next = UPDATE;
          idx_next   = '0;
        end
      end
      UPDATE: begin
        idx_next = idx + CW'(1);
        if (idx == LAST_CH) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign cmd.cmd_ready = ready;
  assign fire          = cmd.cmd_valid && ready;

  // Commands only land in IDLE and sweep writes only in UPDATE, so they never collide.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < NCH; k++) begin
        duty[k]   <= INIT;
        target[k] <= INIT;
        step[k]   <= 4'd0;
      end
    end else begin
      if (fire) begin
        target[cmd.cmd_ch] <= cmd.cmd_target;
        step[cmd.cmd_ch]   <= cmd.cmd_step;
        if (cmd.cmd_step == 4'd0) duty[cmd.cmd_ch] <= cmd.cmd_target;
      end
      if (state == UPDATE) duty[idx] <= step_toward(duty[idx], target[idx], step[idx]);
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_out
    assign duty_flat[8*k +: 8] = duty[k];
    assign moving[k]           = (duty[k] != target[k]);
  end
endmodule

// File: tb/tb_servo_ramp_ctrl.sv
// Directed bench for servo_ramp_ctrl with FRAME = 10 and four channels; duty expectations go
// through a scoreboard queue and are popped when the DUT output is sampled.
module tb_servo_ramp_ctrl;
  localparam int NCH = 4;

  logic             clk;
  logic             rst;
  logic             enable;
  logic [NCH*8-1:0] duty_flat;
  logic [NCH-1:0]   moving;
  logic             frame_tick;
  logic             pdm_en;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    int         ch;
    logic [7:0] val;
  } exp_t;
  exp_t sb[$];

  servo_ramp_ctrl_if #(.NCH(NCH)) bus ();

  servo_ramp_ctrl #(
    .clk_hz(1000), .cyc_hz(100), .NCH(NCH), .INIT_DUTY(128)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .cmd(bus),
    .duty_flat(duty_flat), .moving(moving), .frame_tick(frame_tick), .pdm_en(pdm_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] duty_of(input int ch);
    return duty_flat[ch*8 +: 8];
  endfunction

  task automatic expect_duty(input string tag, input int ch, input logic [7:0] v);
    exp_t e;
    e.tag = tag;
    e.ch  = ch;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check_sb();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, 32'(duty_of(e.ch)), 32'(e.val));
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tick();
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 25 && !seen; n++) begin
      @(negedge clk);
      if (frame_tick) seen = 1'b1;
    end
    chk("tick_seen", 32'(seen), 32'd1);
  endtask

  task automatic send(input int ch, input logic [7:0] t, input logic [3:0] s);
    bit got;
    got = 1'b0;
    @(negedge clk);
    bus.cmd_valid  = 1'b1;
    bus.cmd_ch     = 2'(ch);
    bus.cmd_target = t;
    bus.cmd_step   = s;
    for (int i = 0; i < 25 && !got; i++) begin
      if (bus.cmd_ready) got = 1'b1;
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    chk("cmd_accept", 32'(got), 32'd1);
  endtask

  initial begin
    int gap;
    int exp_seq[4];
    logic [7:0] prev;

    bus.cmd_valid  = 1'b0;
    bus.cmd_ch     = '0;
    bus.cmd_target = '0;
    bus.cmd_step   = '0;
    enable = 1'b1;
    rst    = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    for (int k = 0; k < NCH; k++) expect_duty("rst_duty", k, 8'd128);
    check_sb();
    chk("rst_moving", 32'(moving), 32'd0);
    chk("rst_ready", 32'(bus.cmd_ready), 32'd0);
    chk("rst_pdm_en", 32'(pdm_en), 32'd0);
    chk("rst_tick", 32'(frame_tick), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(bus.cmd_ready), 32'd1);
    chk("pdm_en_follow", 32'(pdm_en), 32'd1);

    // Frame period and enable delay
    wait_tick();
    gap = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (frame_tick) begin
        gap = i;
        break;
      end
    end
    chk("frame_period", 32'(gap), 32'd10);
    enable = 1'b0;
    @(negedge clk);
    chk("pdm_en_off", 32'(pdm_en), 32'd0);
    enable = 1'b1;
    #1;
    chk("pdm_en_delay", 32'(pdm_en), 32'd0);
    @(negedge clk);
    chk("pdm_en_on", 32'(pdm_en), 32'd1);

    // Jump: step 0 sets duty at the accepting edge
    send(2, 8'd200, 4'd0);
    expect_duty("jump_duty2", 2, 8'd200);
    check_sb();
    chk("jump_moving2", 32'(moving[2]), 32'd0);

    // Ramp up on channel 1 by 5 per frame, landing two clocks after the tick
    wait_tick();
    cycles(5);
    send(1, 8'd140, 4'd5);
    expect_duty("ramp_start", 1, 8'd128);
    check_sb();
    chk("ramp_moving_start", 32'(moving[1]), 32'd1);
    exp_seq = '{133, 138, 140, 140};
    prev = 8'd128;
    for (int f = 0; f < 4; f++) begin
      wait_tick();
      cycles(2);
      expect_duty("ramp_hold", 1, prev);
      check_sb();
      cycles(1);
      expect_duty("ramp_step", 1, 8'(exp_seq[f]));
      check_sb();
      chk("ramp_moving", 32'(moving[1]), (exp_seq[f] != 140) ? 32'd1 : 32'd0);
      prev = 8'(exp_seq[f]);
    end
    expect_duty("ramp_ch2_kept", 2, 8'd200);
    check_sb();

    // Ramp down must clamp at the target instead of wrapping
    send(0, 8'd10, 4'd0);
    expect_duty("down_jump", 0, 8'd10);
    check_sb();
    send(0, 8'd0, 4'd15);
    expect_duty("down_wait", 0, 8'd10);
    check_sb();
    wait_tick();
    cycles(2);
    expect_duty("down_clamp", 0, 8'd0);
    check_sb();
    chk("down_moving0", 32'(moving[0]), 32'd0);

    // Command accepted in the tick cycle, then held valid across the sweep
    wait_tick();
    chk("tick_cycle", 32'(frame_tick), 32'd1);
    bus.cmd_valid  = 1'b1;
    bus.cmd_ch     = 2'd3;
    bus.cmd_target = 8'd150;
    bus.cmd_step   = 4'd4;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("sweep_ready_low", 32'(bus.cmd_ready), 32'd0);
    end
    expect_duty("simul_before", 3, 8'd128);
    check_sb();
    @(negedge clk);
    chk("sweep_ready_back", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b0;
    expect_duty("simul_duty3", 3, 8'd132);
    check_sb();
    chk("simul_moving3", 32'(moving[3]), 32'd1);

    // Reset on the second sweep cycle aborts the sweep
    wait_tick();
    cycles(2);
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < NCH; k++) expect_duty("midrst_duty", k, 8'd128);
    check_sb();
    chk("midrst_ready", 32'(bus.cmd_ready), 32'd0);
    chk("midrst_moving", 32'(moving), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_idle", 32'(bus.cmd_ready), 32'd1);
    cycles(2);
    for (int k = 0; k < NCH; k++) expect_duty("midrst_nowrite", k, 8'd128);
    check_sb();
    gap = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (frame_tick) begin
        gap = i;
        break;
      end
    end
    chk("midrst_next_tick", 32'(gap), 32'd6);
    cycles(5);
    for (int k = 0; k < NCH; k++) expect_duty("midrst_after", k, 8'd128);
    check_sb();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
